freq_sweep_controller: RTL and testbench

FREQ_SWEEP_CONTROLLER -- requirements
Module: freq_sweep_controller

---
 rtl/sweep_pkg.sv | 36 +++
 rtl/dwell_timer.sv | 27 ++
 rtl/freq_sweep_controller.sv | 145 ++++++++++++++
 tb/tb_freq_sweep_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared encodings and level helpers for the frequency sweep controller.
package sweep_pkg;

    localparam int LEVEL_W = 3;
    localparam logic [LEVEL_W-1:0] MIN_LEVEL = 3'd0;
    localparam logic [LEVEL_W-1:0] MAX_LEVEL = 3'd7;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_LOOP     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DWELL = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // One level toward target; never moves past target, so it cannot wrap.
    function automatic logic [LEVEL_W-1:0] step_toward(
        input logic [LEVEL_W-1:0] level,
        input logic [LEVEL_W-1:0] target
    );
        logic [LEVEL_W-1:0] result;
        result = level;
        if (target > level && level != MAX_LEVEL) begin
            result = level + 1'b1;
        end else if (target < level && level != MIN_LEVEL) begin
            result = level - 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_value,
    input  logic               enable,
    output logic               expire
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != '0) begin
            count <= count - DWELL_W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/freq_sweep_controller.sv
// Steps a sine generator's frequency select through a level range with a
// programmable dwell per level, in one-shot, loop, ping-pong or hold mode.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_DWELL | holding freq_select for one dwell, then stepping
//   ST_DONE  | one-shot finished, done pulse, back to idle
module freq_sweep_controller
    import sweep_pkg::*;
#(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [LEVEL_W-1:0] start_level,
    input  logic [LEVEL_W-1:0] end_level,
    input  logic [DWELL_W-1:0] dwell,
    output logic [LEVEL_W-1:0] freq_select,
    output logic               gen_reset,
    output logic               busy,
    output logic               step_strobe,
    output logic               done
);

    state_e             state;
    mode_e              mode_q;
    logic [LEVEL_W-1:0] start_q;
    logic [LEVEL_W-1:0] end_q;
    logic [LEVEL_W-1:0] target_q;
    logic [DWELL_W-1:0] reload_q;

    logic               start_accept;
    logic               timer_load;
    logic               timer_expire;
    logic [DWELL_W-1:0] dwell_m1;
    logic [DWELL_W-1:0] timer_value;
    logic [LEVEL_W-1:0] pp_next_target;

    // A dwell of zero behaves as one cycle per level.
    assign dwell_m1       = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign start_accept   = (state == ST_IDLE) && start && !stop;
    assign timer_load     = start_accept || ((state == ST_DWELL) && timer_expire && !stop);
    assign timer_value    = (state == ST_IDLE) ? dwell_m1 : reload_q;
    assign pp_next_target = (target_q == end_q) ? start_q : end_q;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (state == ST_DWELL),
        .expire     (timer_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_ONESHOT;
            start_q     <= '0;
            end_q       <= '0;
            target_q    <= '0;
            reload_q    <= '0;
            freq_select <= '0;
            gen_reset   <= 1'b0;
            busy        <= 1'b0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            gen_reset   <= 1'b0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_accept) begin
                        mode_q      <= mode_e'(mode);
                        start_q     <= start_level;
                        end_q       <= end_level;
                        target_q    <= end_level;
                        reload_q    <= dwell_m1;
                        freq_select <= start_level;
                        gen_reset   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (timer_expire) begin
                        case (mode_q)
                            MODE_ONESHOT: begin
                                if (freq_select == end_q) begin
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= ST_DONE;
                                end else begin
                                    freq_select <= step_toward(freq_select, end_q);
                                    step_strobe <= 1'b1;
                                end
                            end
                            MODE_LOOP: begin
                                if (start_q != end_q) begin
                                    if (freq_select == end_q) begin
                                        freq_select <= start_q;
                                    end else begin
                                        freq_select <= step_toward(freq_select, end_q);
                                    end
                                    step_strobe <= 1'b1;
                                end
                            end
                            MODE_PINGPONG: begin
                                if (start_q != end_q) begin
                                    if (freq_select == target_q) begin
                                        target_q    <= pp_next_target;
                                        freq_select <= step_toward(freq_select, pp_next_target);
                                    end else begin
                                        freq_select <= step_toward(freq_select, target_q);
                                    end
                                    step_strobe <= 1'b1;
                                end
                            end
                            default: begin
                                freq_select <= start_q;
                            end
                        endcase
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_sweep_controller.sv
// Randomized sweeps compared cycle by cycle against a level-list model.
module tb_freq_sweep_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [2:0]  start_level = 3'd0;
    logic [2:0]  end_level = 3'd0;
    logic [15:0] dwell = 16'd0;
    logic [2:0]  freq_select;
    logic        gen_reset;
    logic        busy;
    logic        step_strobe;
    logic        done;

    int checks = 0;
    int errors = 0;
    int model_fs = 0;
    int per[$];

    freq_sweep_controller #(.DWELL_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .start_level (start_level),
        .end_level   (end_level),
        .dwell       (dwell),
        .freq_select (freq_select),
        .gen_reset   (gen_reset),
        .busy        (busy),
        .step_strobe (step_strobe),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Levels visited in one period of the sweep, in order.
    task automatic build_period(input int md, input int s, input int e);
        int dir;
        per.delete();
        dir = (e > s) ? 1 : -1;
        if (md == 3 || (s == e)) begin
            per.push_back(s);
        end else begin
            for (int v = s; v != e; v += dir) per.push_back(v);
            per.push_back(e);
            if (md == 2) begin
                for (int v = e - dir; v != s; v -= dir) per.push_back(v);
            end
        end
    endtask

    function automatic int level_at(input int md, input int n, input int d, input int e);
        int idx;
        idx = n / d;
        if (md == 0) return (idx >= per.size()) ? e : per[idx];
        return per[idx % per.size()];
    endfunction

    // stop_k: edge (counted from the start edge) at which stop is sampled; 0 = none.
    task automatic run_sweep(input int md, input int s, input int e, input int dw, input int stop_k);
        int d, len, last, spur_lim;
        int x_fs, x_busy, x_gen, x_stb, x_done;
        build_period(md, s, e);
        d = (dw == 0) ? 1 : dw;
        len = per.size();
        last = (stop_k != 0) ? stop_k + 1 : len * d + 1;
        spur_lim = (stop_k != 0) ? stop_k : len * d + 1;
        mode = 2'(md); start_level = 3'(s); end_level = 3'(e); dwell = 16'(dw);
        start = 1'b1; stop = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n <= last; n++) begin
            if (stop_k != 0 && n >= stop_k) begin
                x_fs = level_at(md, stop_k - 1, d, e);
                x_busy = 0; x_gen = 0; x_stb = 0; x_done = 0;
            end else if (md == 0 && n >= len * d) begin
                x_fs = e; x_busy = 0; x_gen = 0; x_stb = 0;
                x_done = (n == len * d) ? 1 : 0;
            end else begin
                x_fs = level_at(md, n, d, e);
                x_busy = 1;
                x_gen = (n == 0) ? 1 : 0;
                x_stb = (n > 0 && n % d == 0 && len > 1) ? 1 : 0;
                x_done = 0;
            end
            chk($sformatf("freq_select m%0d %0d->%0d d%0d n%0d", md, s, e, dw, n), freq_select, x_fs);
            chk($sformatf("busy n%0d", n), busy, x_busy);
            chk($sformatf("gen_reset n%0d", n), gen_reset, x_gen);
            chk($sformatf("step_strobe m%0d %0d->%0d d%0d n%0d", md, s, e, dw, n), step_strobe, x_stb);
            chk($sformatf("done n%0d", n), done, x_done);
            model_fs = x_fs;
            stop = (stop_k != 0 && n + 1 == stop_k);
            start = (n + 1 <= spur_lim) && ($urandom_range(0, 3) == 0);
            mode = 2'($urandom);
            start_level = 3'($urandom);
            end_level = 3'($urandom);
            dwell = 16'($urandom_range(0, 5));
            @(negedge clk);
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic idle_collision();
        start = 1'b1; stop = 1'b1;
        mode = 2'($urandom); start_level = 3'($urandom); end_level = 3'($urandom);
        dwell = 16'($urandom_range(0, 5));
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("collision busy", busy, 0);
        chk("collision gen_reset", gen_reset, 0);
        chk("collision freq_select", freq_select, model_fs);
        @(negedge clk);
        chk("collision busy later", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " freq_select"}, freq_select, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " gen_reset"}, gen_reset, 0);
        chk({tag, " step_strobe"}, step_strobe, 0);
        chk({tag, " done"}, done, 0);
    endtask

    initial begin
        int md, s, e, dw, k, len;
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("post-reset");

        run_sweep(0, 2, 5, 3, 0);
        run_sweep(2, 1, 3, 1, 10);
        run_sweep(1, 6, 4, 0, 9);
        run_sweep(0, 3, 5, 4, 5);
        run_sweep(3, 2, 6, 2, 12);
        run_sweep(1, 5, 5, 1, 8);
        run_sweep(0, 7, 0, 1, 0);
        idle_collision();

        // Reset in the middle of a loop sweep.
        mode = 2'd1; start_level = 3'd0; end_level = 3'd7; dwell = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("async reset");
        @(negedge clk);
        check_all_zero("held reset");
        reset = 1'b0;
        model_fs = 0;
        @(negedge clk);
        run_sweep(0, 7, 7, 2, 0);

        for (int it = 0; it < 40; it++) begin
            md = $urandom_range(0, 3);
            s = $urandom_range(0, 7);
            e = $urandom_range(0, 7);
            dw = $urandom_range(0, 4);
            build_period(md, s, e);
            len = per.size() * ((dw == 0) ? 1 : dw);
            if (md != 0) k = $urandom_range(1, 25);
            else if ($urandom_range(0, 2) == 0) k = $urandom_range(1, len);
            else k = 0;
            if ($urandom_range(0, 3) == 0) idle_collision();
            run_sweep(md, s, e, dw, k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
